vga_sync_timing_core: RTL and testbench

VGA_SYNC_TIMING_CORE -- requirements
Module: vga_sync_timing_core

---
 rtl/vga_sync_timing_core.sv | 121 ++++++++++++
 tb/tb_vga_sync_timing_core.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_timing_core.sv
// VGA pixel-clock divider, x/y raster counters, delay-aligned active-low syncs, blanked RGB register.
// Latency: syncs/video_on/vga_rgb lag x,y by one pixel tick, or DELAY ticks when VGA_SYNC_DELAY_EN is defined.
// Backpressure: none; free-running raster, rgb_in is sampled on every pixel tick.
module vga_sync_timing_core #(
    parameter int CD      = 12,
    parameter int HD      = 640,
    parameter int HF      = 16,
    parameter int HS      = 96,
    parameter int HB      = 48,
    parameter int VD      = 480,
    parameter int VF      = 10,
    parameter int VS      = 2,
    parameter int VB      = 33,
    parameter int CLK_DIV = 4,
    parameter int DELAY   = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CD-1:0] rgb_in,
    output logic [10:0]   x,
    output logic [10:0]   y,
    output logic          p_tick,
    output logic          frame_start,
    output logic          hsync,
    output logic          vsync,
    output logic          video_on,
    output logic [CD-1:0] vga_rgb
);

    localparam logic [10:0] HT      = 11'(HD + HF + HS + HB);
    localparam logic [10:0] VT      = 11'(VD + VF + VS + VB);
    localparam logic [10:0] H_DISP  = 11'(HD);
    localparam logic [10:0] V_DISP  = 11'(VD);
    localparam logic [10:0] H_SYNC0 = 11'(HD + HF);
    localparam logic [10:0] H_SYNC1 = 11'(HD + HF + HS - 1);
    localparam logic [10:0] V_SYNC0 = 11'(VD + VF);
    localparam logic [10:0] V_SYNC1 = 11'(VD + VF + VS - 1);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

`ifdef VGA_SYNC_DELAY_EN
    localparam int PIPE = DELAY;
`else
    localparam int PIPE = 1;
`endif

    // Stage encoding {hsync, vsync, video_on}; idle = syncs high, blanked.
    localparam logic [2:0] SYNC_IDLE = 3'b110;

    logic [DW-1:0] div;
    logic [DW-1:0] div_nxt;
    logic          x_last;
    logic          y_last;
    logic [2:0]    sync_raw;
    logic [2:0]    sync_nxt;
    logic [2:0]    stage [PIPE];

    always_comb begin
        div_nxt = (div == DIV_MAX) ? '0 : div + DW'(1);
    end

    // p_tick is registered so it stays low in reset even when CLK_DIV=1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div    <= '0;
            p_tick <= 1'b0;
        end else begin
            div    <= div_nxt;
            p_tick <= (div_nxt == DIV_MAX);
        end
    end

    assign x_last = (x == HT - 11'd1);
    assign y_last = (y == VT - 11'd1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x <= '0;
            y <= '0;
        end else if (p_tick) begin
            x <= x_last ? '0 : x + 11'd1;
            if (x_last) begin
                y <= y_last ? '0 : y + 11'd1;
            end
        end
    end

    assign frame_start = p_tick && (x == '0) && (y == '0);

    always_comb begin
        sync_raw[2] = !((x >= H_SYNC0) && (x <= H_SYNC1));
        sync_raw[1] = !((y >= V_SYNC0) && (y <= V_SYNC1));
        sync_raw[0] = (x < H_DISP) && (y < V_DISP);
    end

    // sync_nxt is the value the output stage takes on this tick, so vga_rgb blanks in step with video_on.
    if (PIPE == 1) begin : g_single
        assign sync_nxt = sync_raw;
    end else begin : g_shift
        assign sync_nxt = stage[PIPE-2];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < PIPE; i++) begin
                stage[i] <= SYNC_IDLE;
            end
            vga_rgb <= '0;
        end else if (p_tick) begin
            stage[0] <= sync_raw;
            for (int i = 1; i < PIPE; i++) begin
                stage[i] <= stage[i-1];
            end
            vga_rgb <= sync_nxt[0] ? rgb_in : '0;
        end
    end

    assign {hsync, vsync, video_on} = stage[PIPE-1];

endmodule

// File: tb/tb_vga_sync_timing_core.sv
// Directed bench: reset values, divider start-up, line/frame wraps, sync widths and delays, RGB blanking, async reset.
module tb_vga_sync_timing_core;

    localparam int CD = 12;
    localparam int HD = 640, HF = 16, HS = 96, HB = 48;
    localparam int VD = 6, VF = 2, VS = 2, VB = 2;
    localparam int CLK_DIV = 4;
    localparam int DELAY = 2;
    localparam int HT = HD + HF + HS + HB;
    localparam int VT = VD + VF + VS + VB;
    localparam int LINE_CLKS = HT * CLK_DIV;
    localparam int FRAME_CLKS = LINE_CLKS * VT;
    localparam int RUN_CLKS = FRAME_CLKS + LINE_CLKS;
`ifdef VGA_SYNC_DELAY_EN
    localparam int PIPE = DELAY;
`else
    localparam int PIPE = 1;
`endif

    logic          clk;
    logic          reset;
    logic [CD-1:0] rgb_in;
    logic [10:0]   x;
    logic [10:0]   y;
    logic          p_tick;
    logic          frame_start;
    logic          hsync;
    logic          vsync;
    logic          video_on;
    logic [CD-1:0] vga_rgb;

    vga_sync_timing_core #(
        .CD(CD), .HD(HD), .HF(HF), .HS(HS), .HB(HB),
        .VD(VD), .VF(VF), .VS(VS), .VB(VB),
        .CLK_DIV(CLK_DIV), .DELAY(DELAY)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rgb_in(rgb_in),
        .x(x),
        .y(y),
        .p_tick(p_tick),
        .frame_start(frame_start),
        .hsync(hsync),
        .vsync(vsync),
        .video_on(video_on),
        .vga_rgb(vga_rgb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_x"}, 32'(x), 0);
        check({pfx, "_y"}, 32'(y), 0);
        check({pfx, "_p_tick"}, 32'(p_tick), 0);
        check({pfx, "_frame_start"}, 32'(frame_start), 0);
        check({pfx, "_hsync"}, 32'(hsync), 1);
        check({pfx, "_vsync"}, 32'(vsync), 1);
        check({pfx, "_video_on"}, 32'(video_on), 0);
        check({pfx, "_vga_rgb"}, 32'(vga_rgb), 0);
    endtask

    logic [10:0] px, py;
    logic        prev_pt, prev_hs, prev_vs;
    logic [36:0] prev_out, cur_out;
    int bad_change, bad_step, bad_fs, bad_rgb;
    int fs_cnt, pt_cnt, vo_cnt, vs_run, vs_max, vs_falls;
    int hs_x_at, hs_fall, hs_rise, waited;
    int exp_x, exp_y;

    initial begin
        reset  = 1'b0;
        rgb_in = 12'hF0F;
        repeat (5) @(negedge clk);
        check_reset_vals("rst");

        px = '0; py = '0; prev_pt = 1'b0; prev_hs = 1'b1; prev_vs = 1'b1;
        prev_out = {x, y, hsync, vsync, video_on, vga_rgb};
        bad_change = 0; bad_step = 0; bad_fs = 0; bad_rgb = 0;
        fs_cnt = 0; pt_cnt = 0; vo_cnt = 0; vs_run = 0; vs_max = 0; vs_falls = 0;
        hs_x_at = -1; hs_fall = -1; hs_rise = -1;
        reset = 1'b1;

        for (int i = 1; i <= RUN_CLKS; i++) begin
            @(negedge clk);
            if (i == 2) check("ptick_clk3", 32'(p_tick), 0);
            if (i == 3) begin
                check("ptick_clk4", 32'(p_tick), 1);
                check("fs_first", 32'(frame_start), 1);
                check("x_at_first_tick", 32'(x), 0);
            end
            if (i == 4) begin
                check("x_after_tick", 32'(x), 1);
                check("ptick_off", 32'(p_tick), 0);
            end
            if (i == LINE_CLKS - 1) begin
                check("x_line_end", 32'(x), HT - 1);
                check("y_line_end", 32'(y), 0);
            end
            if (i == LINE_CLKS) begin
                check("x_wrap", 32'(x), 0);
                check("y_incr", 32'(y), 1);
            end
            if (i == FRAME_CLKS - 1) begin
                check("x_frame_end", 32'(x), HT - 1);
                check("y_frame_end", 32'(y), VT - 1);
            end
            if (i == FRAME_CLKS) begin
                check("x_frame_wrap", 32'(x), 0);
                check("y_frame_wrap", 32'(y), 0);
            end

            cur_out = {x, y, hsync, vsync, video_on, vga_rgb};
            if (!prev_pt && cur_out != prev_out) bad_change++;
            if (prev_pt) begin
                exp_x = (int'(px) == HT - 1) ? 0 : int'(px) + 1;
                exp_y = (int'(px) == HT - 1) ? ((int'(py) == VT - 1) ? 0 : int'(py) + 1) : int'(py);
                if (int'(x) != exp_x || int'(y) != exp_y) bad_step++;
            end
            if (frame_start) begin
                fs_cnt++;
                if (!p_tick || x != 0 || y != 0) bad_fs++;
            end
            if (p_tick) pt_cnt++;
            if (i <= FRAME_CLKS && video_on) vo_cnt++;
            if (vga_rgb !== (video_on ? 12'hF0F : 12'h000)) bad_rgb++;
            if (!vsync) vs_run++;
            else begin
                if (vs_run > vs_max) vs_max = vs_run;
                vs_run = 0;
            end
            if (i <= FRAME_CLKS && !vsync && prev_vs) vs_falls++;
            if (hs_x_at < 0 && x == 11'(HD + HF) && px != 11'(HD + HF)) hs_x_at = i;
            if (hs_fall < 0 && !hsync && prev_hs) hs_fall = i;
            if (hs_fall >= 0 && hs_rise < 0 && hsync && !prev_hs) hs_rise = i;

            px = x; py = y; prev_pt = p_tick; prev_hs = hsync; prev_vs = vsync;
            prev_out = cur_out;
        end

        check("change_without_ptick", 32'(bad_change), 0);
        check("xy_step", 32'(bad_step), 0);
        check("fs_placement", 32'(bad_fs), 0);
        check("fs_count", 32'(fs_cnt), 2);
        check("ptick_count", 32'(pt_cnt), RUN_CLKS / CLK_DIV);
        check("video_on_clks", 32'(vo_cnt), HD * VD * CLK_DIV);
        check("rgb_blanking", 32'(bad_rgb), 0);
        check("vsync_low_clks", 32'(vs_max), VS * LINE_CLKS);
        check("vsync_falls", 32'(vs_falls), 1);
        check("x656_clk", 32'(hs_x_at), (HD + HF) * CLK_DIV);
        check("hsync_delay", 32'(hs_fall - hs_x_at), PIPE * CLK_DIV);
        check("hsync_low_clks", 32'(hs_rise - hs_fall), HS * CLK_DIV);

        waited = 0;
        while (!(x == 11'd300 && y == 11'd2) && waited < 20000) begin
            @(negedge clk);
            waited++;
        end
        check("seek_x300_y2", 32'(x == 11'd300 && y == 11'd2), 1);
        check("pre_reset_rgb", 32'(vga_rgb), 32'h0F0F);
        #1 reset = 1'b0;
        #1 check_reset_vals("async_rst");
        repeat (3) @(negedge clk);
        check_reset_vals("held_rst");
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("restart_ptick", 32'(p_tick), 1);
        check("restart_fs", 32'(frame_start), 1);
        @(negedge clk);
        check("restart_x", 32'(x), 1);
        check("restart_y", 32'(y), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
